// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared state encoding, redirect/hold constants, defaults and BTB entry type.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pc_gen_pkg;

  // Front-end PC generator states; BOOT is left on the first edge after reset.
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_t;

  // Asserted value of jump_flag_i.
  localparam logic       JumpEnable = 1'b1;
  // Lowest hold level from ctrl that freezes the PC.
  localparam logic [2:0] HoldEnable = 3'd1;

  localparam int          DEF_ADDR_W     = 32;
  localparam logic [31:0] DEF_RESET_ADDR = 32'h0;
  localparam int          DEF_STRIDE     = 4;

  // BTB fields are sized for the widest supported PC (64 bits); narrower
  // PCs are stored zero-extended, so the unused upper bits are constant.
  localparam int BTB_FIELD_W = 64;

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
  } btb_entry_t;

  // Index width of a direct-mapped table with the given number of entries.
  function automatic int btb_idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: redirect/hold/update inputs and the fetch-address output bundle of pc_gen.
// Latency: none (wiring only).
// Backpressure: pc_ready_i from if_id and hold_flag_i from ctrl freeze pc_o.
interface pc_gen_if
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              trap_flag_i;
  logic [ADDR_W-1:0] trap_addr_i;
  logic              jump_flag_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic [2:0]        hold_flag_i;
  logic              pc_ready_i;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] pc_o;
  logic              pc_valid_o;
  logic              pred_taken_o;

  // PC generator side.
  modport master (
    input  trap_flag_i, trap_addr_i, jump_flag_i, jump_addr_i, hold_flag_i,
    input  pc_ready_i, upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
    output pc_o, pc_valid_o, pred_taken_o
  );

  // ctrl / if_id side.
  modport slave (
    output trap_flag_i, trap_addr_i, jump_flag_i, jump_addr_i, hold_flag_i,
    output pc_ready_i, upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
    input  pc_o, pc_valid_o, pred_taken_o
  );

endinterface

// File: rtl/pc_btb.sv
// pc_btb: direct-mapped branch target buffer, combinational lookup, update on the clock edge.
// Latency: lookup 0 cycles; an update becomes visible to lookups one cycle later.
// Backpressure: none; every upd_valid strobe is applied on the edge it is seen.
module pc_btb
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BTB_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              hit,
  output logic [ADDR_W-1:0] target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken
);

  localparam int IDX_W = btb_idx_w(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  btb_entry_t        mem [BTB_DEPTH];
  btb_entry_t        rd_entry;
  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_match;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_lsb;
  assign unused_lsb = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];

  // Lookup reads the registered table, so a same-cycle update is not seen yet.
  assign rd_entry = mem[lk_idx];
  assign hit      = rd_entry.valid && (rd_entry.tag == BTB_FIELD_W'(lk_tag));
  assign target   = ADDR_W'(rd_entry.target);

  // Invalidation only removes the entry if it still belongs to the resolved PC.
  assign up_match = mem[up_idx].valid && (mem[up_idx].tag == BTB_FIELD_W'(up_tag));

  // Table storage: reset empties it; taken allocates/overwrites, not-taken invalidates on tag match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        mem[up_idx] <= '{valid:  1'b1,
                         tag:    BTB_FIELD_W'(up_tag),
                         target: BTB_FIELD_W'(upd_target)};
      end else if (up_match) begin
        mem[up_idx].valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator (trap > jump > hold > not-ready > BTB prediction > +STRIDE); BTB under PC_GEN_BTB_EN.
// Latency: 1 cycle from redirect/selection inputs to pc_o; pc_valid_o rises on the first edge after reset.
// Backpressure: !pc_ready_i or hold_flag_i >= HOLD_LEVEL keeps pc_o stable; redirects override both.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DEF_RESET_ADDR),
  parameter int                STRIDE     = DEF_STRIDE,
  parameter int                HOLD_LEVEL = int'(HoldEnable),
  parameter int                BTB_DEPTH  = 8
) (
  input logic       clk,
  input logic       rst_n,
  pc_gen_if.master  bus
);

  pc_state_t         state_q;
  pc_state_t         state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] trap_tgt;
  logic [ADDR_W-1:0] jump_tgt;
  logic              hold_stall;
  logic              pred_taken;

  // Redirect targets are always word aligned.
  assign trap_tgt   = {bus.trap_addr_i[ADDR_W-1:2], 2'b00};
  assign jump_tgt   = {bus.jump_addr_i[ADDR_W-1:2], 2'b00};
  assign hold_stall = int'(bus.hold_flag_i) >= HOLD_LEVEL;

  // Alignment drops the low target bits.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^{bus.trap_addr_i[1:0], bus.jump_addr_i[1:0]};

`ifdef PC_GEN_BTB_EN
  logic              btb_hit;
  logic [ADDR_W-1:0] pred_target;

  pc_btb #(
    .ADDR_W    (ADDR_W),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_pc  (pc_q),
    .hit        (btb_hit),
    .target     (pred_target),
    .upd_valid  (bus.upd_valid_i),
    .upd_pc     (bus.upd_pc_i),
    .upd_target (bus.upd_target_i),
    .upd_taken  (bus.upd_taken_i)
  );

  // A prediction is only meaningful for a PC that is actually being presented.
  assign pred_taken = btb_hit && (state_q == ST_RUN);
`else
  assign pred_taken = 1'b0;

  // Without a BTB the update port from ctrl has no consumer.
  logic unused_upd;
  assign unused_upd = ^{bus.upd_valid_i, bus.upd_pc_i, bus.upd_target_i, bus.upd_taken_i};
`endif

  // State and PC registers; reset is asynchronous and returns to BOOT at RESET_ADDR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state and next-PC selection; redirects apply in BOOT too, the rest only in RUN.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    if (bus.trap_flag_i) begin
      pc_d = trap_tgt;
    end else if (bus.jump_flag_i == JumpEnable) begin
      pc_d = jump_tgt;
    end else if (state_q != ST_RUN) begin
      pc_d = pc_q;
    end else if (hold_stall || !bus.pc_ready_i) begin
      pc_d = pc_q;
`ifdef PC_GEN_BTB_EN
    end else if (pred_taken) begin
      pc_d = pred_target;
`endif
    end else begin
      pc_d = pc_q + ADDR_W'(STRIDE);
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.pc_valid_o   = (state_q == ST_RUN);
  assign bus.pred_taken_o = pred_taken;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the core front end: produces the fetch address each cycle toward if_id with a valid/ready handshake. Redirects from ctrl take priority in this order: trap, then jump. Pipeline hold and fetch back-pressure stall the PC. An optional branch target buffer (BTB) predicts taken jumps so sequential fetch can follow them without waiting for ctrl.

## Interface
Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_ADDR, 32'h0, value loaded into pc_o on reset.
- STRIDE, 4, sequential increment in bytes.
- HOLD_LEVEL, 1, minimum hold_flag_i value that stalls the PC.
- BTB_DEPTH, 8, number of BTB entries (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- trap_flag_i  in  1  trap redirect request.
- trap_addr_i  in  ADDR_W  trap target.
- jump_flag_i  in  1  jump redirect request (JumpEnable = 1).
- jump_addr_i  in  ADDR_W  jump target.
- hold_flag_i  in  3  pipeline hold level from ctrl.
- pc_ready_i  in  1  if_id accepts the current PC.
- upd_valid_i  in  1  BTB update strobe from ctrl.
- upd_pc_i  in  ADDR_W  PC of the resolved jump.
- upd_target_i  in  ADDR_W  resolved target.
- upd_taken_i  in  1  1 = allocate or overwrite the entry; 0 = invalidate it on tag match.
- pc_o  out  ADDR_W  current fetch address.
- pc_valid_o  out  1  pc_o is presentable to if_id.
- pred_taken_o  out  1  BTB hit on pc_o; the next PC is the BTB target.

## Operation
- States: BOOT, RUN.
  - Reset forces BOOT with pc_o=RESET_ADDR, pc_valid_o=0, pred_taken_o=0.
  - BOOT→RUN on the first clock edge after rst_n release; pc_valid_o=1 from then on.
  - There is no path back to BOOT except reset.
- Next-PC selection in RUN, highest priority first:
  1. trap_flag_i → trap_addr_i.
  2. jump_flag_i → jump_addr_i.
  3. hold_flag_i ≥ HOLD_LEVEL → pc_o unchanged.
  4. !pc_ready_i → pc_o unchanged.
  5. pred_taken_o → BTB target.
  6. Otherwise → pc_o + STRIDE.
- Redirects (1 and 2) ignore hold and ready. Redirect targets have bits [1:0] forced to 0.
- Sequential increment wraps modulo 2^ADDR_W (for example, 32'hFFFF_FFFC → 32'h0).
- A redirect arriving while in BOOT is applied: pc_o takes the target and the state still enters RUN.
- Reset mid-operation:
  - returns pc_o to RESET_ADDR and the state to BOOT immediately (asynchronous);
  - clears all BTB valid bits.
- BTB organisation:
  - direct-mapped; index = pc[IDX_W+1:2], tag = pc[ADDR_W-1:IDX_W+2], IDX_W = log2(BTB_DEPTH);
  - each entry holds {valid, tag, target}.
- BTB lookup: combinational on pc_o. pred_taken_o = valid && tag match && pc_valid_o.
- BTB update, on the clock edge when upd_valid_i:
  - upd_taken_i=1 writes the entry at the index of upd_pc_i, valid=1;
  - upd_taken_i=0 clears valid only if the stored tag matches.
- Update and lookup on the same index in the same cycle: the lookup sees the pre-update contents.

## Timing
- Next-PC selection is registered: a redirect asserted in cycle N makes pc_o = target in cycle N+1.
- Handshake: a PC is consumed in a cycle with pc_valid_o && pc_ready_i && hold below HOLD_LEVEL.
  - pc_o is stable while it is not consumed.
  - pc_valid_o never drops in RUN.
- A BTB update at edge N influences the lookup from cycle N+1.
- A lookup and a redirect in the same cycle: the redirect wins and the prediction is discarded.

## Configuration
- Macro PC_GEN_BTB_EN.
- Defined: BTB storage, the lookup, and the upd_* handling are compiled in.
- Undefined:
  - no BTB storage is instantiated and pred_taken_o is tied to 0;
  - upd_* inputs are ignored;
  - selection step 5 is removed.

## Structure
- Shared package pc_gen_pkg holds:
  - the state encoding (BOOT, RUN);
  - the JumpEnable and HoldEnable constants;
  - the default RESET_ADDR and STRIDE;
  - the BTB entry struct {valid, tag, target}.
- Sub-module pc_btb (BTB_DEPTH, ADDR_W) holds the storage, lookup, and update logic. It is instantiated only under PC_GEN_BTB_EN.

## Test plan
- Reset with RESET_ADDR=32'h8000_0000, release rst_n, hold pc_ready_i=1 → cycle 0: pc_valid_o=0; then pc_o = 8000_0000, 8000_0004, 8000_0008.
- Apply trap_flag_i, trap_addr_i=32'h100, and jump_flag_i, jump_addr_i=32'h200, with hold_flag_i=3, all in the same cycle → pc_o=32'h100 next cycle.
- Apply hold_flag_i=1 for 3 cycles at pc_o=32'h40 → pc_o stays 32'h40; it advances to 32'h44 the cycle after the hold is released. Repeat with pc_ready_i=0 → same result.
- Start pc_o at 32'hFFFF_FFF8 with STRIDE=4 → pc_o = FFFF_FFFC, then 0000_0000.
- With PC_GEN_BTB_EN: apply upd_valid_i, upd_pc_i=32'h20, upd_target_i=32'h80, upd_taken_i=1, then fetch through 32'h20 → pred_taken_o=1 at 32'h20 and the next pc_o=32'h80. Then update with upd_taken_i=0 for the same PC → the next visit to 32'h20 gives 32'h24.
- Assert rst_n low while pc_o=32'h80 and the BTB is populated → pc_o=RESET_ADDR and pc_valid_o=0 asynchronously; after restart, 32'h20 no longer predicts.
